// File: rtl/nn_accel_pkg.sv
// nn_accel_pkg: shared constants, state encoding and descriptor checks for the layer sequencer.
package nn_accel_pkg;
  localparam int PE_WIDTH    = 16;
  localparam int DW          = 16;
  localparam int DESC_STRIDE = 8;
  localparam int LAYER_W     = 5;
  localparam int DESC_IN     = 0;
  localparam int DESC_W      = 1;
  localparam int DESC_OUT    = 2;
  localparam int DESC_NIN    = 3;
  localparam int DESC_NOUT   = 4;
  localparam int NUM_WORDS   = 5;
  typedef enum logic [3:0] {IDLE, FETCH, CHECK, LAUNCH, CONFIG, RUN, NEXT, DONE, ABORT} state_t;
  function automatic logic desc_bad(input logic [DW-1:0] n_in, input logic [DW-1:0] n_out);
    return n_in == '0 || (n_in % DW'(PE_WIDTH)) != '0 || n_out == '0;
  endfunction
endpackage

// File: rtl/nn_desc_fetch.sv
// nn_desc_fetch: strobes five descriptor reads and captures each word one cycle after its strobe.
module nn_desc_fetch
  import nn_accel_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_go,
  input  logic [15:0]                   base,
  input  logic [DW-1:0]                 desc_data,
  output logic                          desc_rd,
  output logic [15:0]                   desc_addr,
  output logic                          fetch_done,
  output logic [NUM_WORDS-1:0][DW-1:0]  words
);
  logic [2:0] cnt, k_q;
  logic       rd_q;
  assign desc_rd    = fetch_go && cnt < 3'(NUM_WORDS);
  assign desc_addr  = base + 16'(cnt);
  assign fetch_done = fetch_go && cnt == 3'(NUM_WORDS);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      k_q   <= '0;
      rd_q  <= 1'b0;
      words <= '0;
    end else begin
      cnt  <= fetch_go ? cnt + 3'd1 : 3'd0;
      rd_q <= desc_rd;
      k_q  <= cnt;
      if (rd_q) words[k_q] <= desc_data;
    end
  end
endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: fetches and validates per-layer descriptors, launches and configures
// the MAC accelerator, and counts output neurons until every layer has run.
module nn_layer_sequencer
  import nn_accel_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [15:0]        desc_base,
  input  logic [LAYER_W-1:0] num_layers,
  output logic               desc_rd,
  output logic [15:0]        desc_addr,
  input  logic [DW-1:0]      desc_data,
  output logic               Enable,
  output logic [DW-1:0]      databus,
  output logic               busrdwr,
  input  logic               neuron_done,
  output logic               acc_soft_rst,
  output logic               busy,
  output logic               layer_done,
  output logic               all_done,
  output logic               error,
  output logic [LAYER_W-1:0] cur_layer,
  output logic [15:0]        neuron_cnt
);
  state_t                      state;
  logic [15:0]                 base_q, fetch_base;
  logic [LAYER_W-1:0]          layers_q;
  logic [2:0]                  cfg_k;
  logic                        nd_q, fetch_done;
  logic [NUM_WORDS-1:0][DW-1:0] words;
  assign fetch_base = base_q + 16'(cur_layer * DESC_STRIDE);
  nn_desc_fetch u_fetch (
    .clk        (clk),
    .rst        (rst),
    .fetch_go   (state == FETCH),
    .base       (fetch_base),
    .desc_data  (desc_data),
    .desc_rd    (desc_rd),
    .desc_addr  (desc_addr),
    .fetch_done (fetch_done),
    .words      (words)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      base_q       <= '0;
      layers_q     <= '0;
      cfg_k        <= '0;
      nd_q         <= 1'b0;
      Enable       <= 1'b0;
      databus      <= '0;
      busrdwr      <= 1'b0;
      acc_soft_rst <= 1'b1;
      busy         <= 1'b0;
      layer_done   <= 1'b0;
      all_done     <= 1'b0;
      error        <= 1'b0;
      cur_layer    <= '0;
      neuron_cnt   <= '0;
    end else begin
      Enable       <= 1'b0;
      databus      <= '0;
      busrdwr      <= 1'b0;
      acc_soft_rst <= 1'b1;
      layer_done   <= 1'b0;
      all_done     <= 1'b0;
      nd_q         <= neuron_done;
      // abort outranks every other transition, including a same-cycle layer completion
      if (abort && state != IDLE) begin
        state        <= ABORT;
        acc_soft_rst <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            base_q    <= desc_base;
            layers_q  <= num_layers;
            busy      <= 1'b1;
            error     <= 1'b0;
            cur_layer <= '0;
            all_done  <= num_layers == '0;
            state     <= num_layers == '0 ? DONE : FETCH;
          end
          FETCH: if (fetch_done) state <= CHECK;
          CHECK: if (desc_bad(words[DESC_NIN], words[DESC_NOUT])) begin
            error        <= 1'b1;
            acc_soft_rst <= 1'b0;
            state        <= ABORT;
          end else begin
            Enable     <= 1'b1;
            neuron_cnt <= '0;
            state      <= LAUNCH;
          end
          LAUNCH: begin
            busrdwr <= 1'b1;
            databus <= words[DESC_IN];
            cfg_k   <= 3'd1;
            state   <= CONFIG;
          end
          CONFIG: if (cfg_k == 3'(NUM_WORDS)) state <= RUN;
          else begin
            busrdwr <= 1'b1;
            databus <= words[cfg_k];
            cfg_k   <= cfg_k + 3'd1;
          end
          RUN: if (neuron_done && !nd_q) begin
            neuron_cnt <= neuron_cnt + 16'd1;
            if (neuron_cnt + 16'd1 == words[DESC_NOUT]) begin
              layer_done <= 1'b1;
              state      <= NEXT;
            end
          end
          NEXT: begin
            cur_layer <= cur_layer + 1'b1;
            all_done  <= !(cur_layer + 1'b1 < layers_q);
            state     <= cur_layer + 1'b1 < layers_q ? FETCH : DONE;
          end
          DONE, ABORT: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
